// File: rtl/gb_apu_pkg.sv
// Shared Game Boy APU definitions: wave-RAM arbiter states and wave-RAM types.
package gb_apu_pkg;

  localparam int WAVE_RAM_DEPTH = 16;

  typedef logic [3:0] wave_addr_t;
  typedef logic [7:0] wave_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CH   = 2'd1,
    CPU  = 2'd2
  } wave_arb_state_t;

  // Four-bit saturating increment used by the CPU stall counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/gb_apu_wave_ram.sv
// 16x8 custom-wave register file: one write port, one combinational read port,
// every byte returns to INIT_BYTE on reset.
module gb_apu_wave_ram
  import gb_apu_pkg::*;
#(
  parameter wave_byte_t INIT_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  wave_addr_t waddr,
  input  wave_byte_t wdata,
  input  wave_addr_t raddr,
  output wave_byte_t rdata
);

  wave_byte_t mem_q [WAVE_RAM_DEPTH];
  wave_byte_t mem_d [WAVE_RAM_DEPTH];

  // Next contents: single byte replaced when the write port is enabled.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage, reinitialised on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WAVE_RAM_DEPTH; i++) begin
        mem_q[i] <= INIT_BYTE;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/gb_apu_wave_ram_ctrl.sv
// Ch 3 wave-RAM controller: arbitrates the single RAM port between channel
// sample fetches (priority) and handshaked CPU accesses, with a stall guard.
// The RAM access of a slot happens at the edge that enters its state, so
// ch_valid / cpu_ack are decodes of the registered state.
// Optional macro GB_APU_WAVE_DMG_QUIRK_EN: while the channel is active, CPU
// accesses alias to the most recently fetched wave address.
module gb_apu_wave_ram_ctrl
  import gb_apu_pkg::*;
#(
  parameter int         MAX_WAIT  = 4,
  parameter wave_byte_t INIT_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ch_active,
  input  logic       ch_req,
  input  wave_addr_t ch_addr,
  output wave_byte_t ch_data,
  output logic       ch_valid,
  output logic       ch_overrun,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  wave_addr_t cpu_addr,
  input  wave_byte_t cpu_wdata,
  output logic       cpu_ack,
  output wave_byte_t cpu_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  wave_arb_state_t state_q, state_d;
  logic            pend_valid_q, pend_valid_d;
  wave_addr_t      pend_addr_q, pend_addr_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  wave_byte_t      ch_data_q, ch_data_d;
  logic            ch_overrun_q, ch_overrun_d;
  wave_byte_t      cpu_rdata_q, cpu_rdata_d;

  logic       fetch_vld;
  wave_addr_t fetch_addr;
  logic       cpu_ack_w;
  logic       cpu_want;
  wave_addr_t cpu_eff_addr;
  logic       ram_we;
  wave_addr_t ram_raddr;
  wave_byte_t ram_rdata;

  // A fresh request supersedes whatever is pending; the displaced entry is an overrun.
  assign fetch_vld  = ch_active & (pend_valid_q | ch_req);
  assign fetch_addr = ch_req ? ch_addr : pend_addr_q;
  assign cpu_ack_w  = (state_q == CPU);
  assign cpu_want   = cpu_req & ~cpu_ack_w;

`ifdef GB_APU_WAVE_DMG_QUIRK_EN
  wave_addr_t last_ch_addr_q, last_ch_addr_d;

  // Track the address of the latest serviced fetch for DMG aliasing.
  always_comb begin
    last_ch_addr_d = last_ch_addr_q;
    if (state_d == CH) begin
      last_ch_addr_d = fetch_addr;
    end
  end

  // Alias register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_ch_addr_q <= '0;
    end else begin
      last_ch_addr_q <= last_ch_addr_d;
    end
  end

  assign cpu_eff_addr = ch_active ? last_ch_addr_q : cpu_addr;
`else
  assign cpu_eff_addr = cpu_addr;
`endif

  // Arbiter next state: channel first unless the CPU has waited MAX_WAIT cycles.
  always_comb begin
    state_d = IDLE;
    if (fetch_vld && (wait_cnt_q < MAX_WAIT_C)) begin
      state_d = CH;
    end else if (cpu_want) begin
      state_d = CPU;
    end else if (fetch_vld) begin
      state_d = CH;
    end
  end

  assign ram_we    = (state_d == CPU) & cpu_we;
  assign ram_raddr = (state_d == CPU) ? cpu_eff_addr : fetch_addr;

  // Datapath, pending slot, overrun flag and CPU stall counter.
  always_comb begin
    ch_data_d    = ch_data_q;
    cpu_rdata_d  = cpu_rdata_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    ch_overrun_d = ch_overrun_q | (ch_active & ch_req & pend_valid_q);
    wait_cnt_d   = sat_inc4(wait_cnt_q);

    if (state_d == CH) begin
      ch_data_d = ram_rdata;
    end
    if ((state_d == CPU) && !cpu_we) begin
      cpu_rdata_d = ram_rdata;
    end

    if (!ch_active) begin
      pend_valid_d = 1'b0;
    end else if (state_d == CH) begin
      pend_valid_d = 1'b0;
    end else if (ch_req) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = ch_addr;
    end

    if (!cpu_req || cpu_ack_w) begin
      wait_cnt_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      wait_cnt_q   <= '0;
      ch_data_q    <= '0;
      ch_overrun_q <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      wait_cnt_q   <= wait_cnt_d;
      ch_data_q    <= ch_data_d;
      ch_overrun_q <= ch_overrun_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  gb_apu_wave_ram #(
    .INIT_BYTE (INIT_BYTE)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (ram_we),
    .waddr (cpu_eff_addr),
    .wdata (cpu_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign ch_data    = ch_data_q;
  assign ch_valid   = (state_q == CH);
  assign ch_overrun = ch_overrun_q;
  assign cpu_ack    = cpu_ack_w;
  assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_gb_apu_wave_ram_ctrl.sv
// Directed bench for gb_apu_wave_ram_ctrl (MAX_WAIT = 4, INIT_BYTE = 0).
module tb_gb_apu_wave_ram_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ch_active;
  logic       ch_req;
  logic [3:0] ch_addr;
  logic [7:0] ch_data;
  logic       ch_valid;
  logic       ch_overrun;
  logic       cpu_req;
  logic       cpu_we;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;

  int total = 0;
  int bad   = 0;

  gb_apu_wave_ram_ctrl #(
    .MAX_WAIT  (4),
    .INIT_BYTE (8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_active  (ch_active),
    .ch_req     (ch_req),
    .ch_addr    (ch_addr),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .ch_overrun (ch_overrun),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs set and outputs read afterwards belong to the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One CPU access with a bounded wait for cpu_ack; returns one cycle after the ack.
  task automatic cpu_xfer(input logic we, input logic [3:0] a, input logic [7:0] d);
    int n;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_ack && n < 20);
    chk("xfer_ack", 8'(cpu_ack), 8'h01);
    cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    logic [3:0] n4;
    logic [7:0] exp0;
    logic [7:0] exp9;

    reset     = 1'b1;
    ch_active = 1'b0;
    ch_req    = 1'b0;
    ch_addr   = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_ch_data",    ch_data,             8'h00);
    chk("rst_ch_valid",   8'(ch_valid),        8'h00);
    chk("rst_ch_overrun", 8'(ch_overrun),      8'h00);
    chk("rst_cpu_ack",    8'(cpu_ack),         8'h00);
    chk("rst_cpu_rdata",  cpu_rdata,           8'h00);

    // Uncontested CPU read of address 5.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 4'd5;
    tick();
    chk("t1_ack", 8'(cpu_ack), 8'h01);
    cpu_req = 1'b0;
    tick();
    chk("t1_ack_single", 8'(cpu_ack), 8'h00);
    chk("t1_rdata", cpu_rdata, 8'h00);

    for (int i = 0; i < 16; i++) begin
      cpu_xfer(1'b1, 4'(i), 8'hF0);
    end

    // Uncontested fetch: one cycle latency.
    ch_active = 1'b1;
    ch_req    = 1'b1;
    ch_addr   = 4'd3;
    tick();
    chk("t2_valid", 8'(ch_valid), 8'h01);
    chk("t2_data", ch_data, 8'hF0);
    ch_req = 1'b0;
    tick();
    chk("t2_valid_pulse", 8'(ch_valid), 8'h00);

    // CPU write then fetch of the same byte in the following slot.
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 4'd3;
    cpu_wdata = 8'h5A;
    tick();
    chk("wf_ack", 8'(cpu_ack), 8'h01);
    cpu_req = 1'b0;
    ch_req  = 1'b1;
    ch_addr = 4'd3;
    tick();
    chk("wf_valid", 8'(ch_valid), 8'h01);
    chk("wf_data", ch_data, 8'h5A);
    ch_req = 1'b0;
    tick();

    ch_active = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n4 = 4'(i);
      cpu_xfer(1'b1, n4, {n4, n4});
    end

    // Starvation guard: channel fetches every cycle (cycles 0..4), CPU held.
    ch_active = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 4'hC;
    ch_req    = 1'b1;
    ch_addr   = 4'd0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n4 = 4'(k - 1);
      chk("t3_valid", 8'(ch_valid), 8'h01);
      chk("t3_data", ch_data, {n4, n4});
      chk("t3_no_ack", 8'(cpu_ack), 8'h00);
      ch_addr = 4'(k);
    end
    tick();
    chk("t3_forced_ack", 8'(cpu_ack), 8'h01);
    chk("t3_ch_held", 8'(ch_valid), 8'h00);
    ch_req  = 1'b0;
    cpu_req = 1'b0;
    tick();
    chk("t3_late_valid", 8'(ch_valid), 8'h01);
    chk("t3_late_data", ch_data, 8'h44);
    chk("t3_no_overrun", 8'(ch_overrun), 8'h00);
    chk("t3_ack_single", 8'(cpu_ack), 8'h00);
    tick();
    chk("t3_idle", 8'(ch_valid), 8'h00);

    // Overrun: addr 2 then addr 7 while the CPU owns the forced slot.
    cpu_req  = 1'b1;
    cpu_addr = 4'hC;
    ch_req   = 1'b1;
    ch_addr  = 4'd1;
    repeat (4) tick();
    ch_addr = 4'd2;
    tick();
    chk("t4_ack", 8'(cpu_ack), 8'h01);
    chk("t4_no_valid", 8'(ch_valid), 8'h00);
    chk("t4_overrun_pre", 8'(ch_overrun), 8'h00);
    ch_addr = 4'd7;
    cpu_req = 1'b0;
    tick();
    chk("t4_valid", 8'(ch_valid), 8'h01);
    chk("t4_data", ch_data, 8'h77);
    chk("t4_overrun", 8'(ch_overrun), 8'h01);
    ch_req = 1'b0;
    tick();
    chk("t4_single_valid", 8'(ch_valid), 8'h00);
    chk("t4_sticky", 8'(ch_overrun), 8'h01);

    // Channel disabled with a fetch pending.
    cpu_req  = 1'b1;
    cpu_addr = 4'd1;
    ch_req   = 1'b1;
    ch_addr  = 4'd5;
    repeat (4) tick();
    ch_addr = 4'd6;
    tick();
    chk("t5_ack", 8'(cpu_ack), 8'h01);
    ch_active = 1'b0;
    ch_req    = 1'b0;
    cpu_req   = 1'b0;
    tick();
    chk("t5_dropped", 8'(ch_valid), 8'h00);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 4'd1;
    tick();
    chk("t5_immediate_ack", 8'(cpu_ack), 8'h01);
    cpu_req = 1'b0;
    tick();
    chk("t5_rdata", cpu_rdata, 8'h11);
    tick();
    chk("t5_no_late_valid", 8'(ch_valid), 8'h00);

    // Fetch addr 9, then CPU write 0xAA to addr 0 while the channel is active.
    ch_active = 1'b1;
    ch_req    = 1'b1;
    ch_addr   = 4'd9;
    tick();
    chk("t6_valid", 8'(ch_valid), 8'h01);
    chk("t6_data", ch_data, 8'h99);
    ch_req    = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 4'd0;
    cpu_wdata = 8'hAA;
    tick();
    chk("t6_ack", 8'(cpu_ack), 8'h01);
    cpu_req   = 1'b0;
    ch_active = 1'b0;
    tick();
`ifdef GB_APU_WAVE_DMG_QUIRK_EN
    exp0 = 8'h00;
    exp9 = 8'hAA;
`else
    exp0 = 8'hAA;
    exp9 = 8'h99;
`endif
    cpu_xfer(1'b0, 4'd0, 8'h00);
    chk("t6_ram0", cpu_rdata, exp0);
    cpu_xfer(1'b0, 4'd9, 8'h00);
    chk("t6_ram9", cpu_rdata, exp9);

    // Reset reinitialises RAM and clears the sticky overrun.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst2_overrun", 8'(ch_overrun), 8'h00);
    chk("rst2_ch_data", ch_data, 8'h00);
    cpu_xfer(1'b0, 4'd7, 8'h00);
    chk("rst2_ram7", cpu_rdata, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
